regfile_scoreboard: RTL

Parametrised multi-read-port register file with a per-register pending-write scoreboard. It is the next-generation replacement for the fixed 32x64, 2-read-port CPU register file. It adds configurable width, depth and read-port count, a hardwired zero register, and a reserve/writeback scoreboard that tells the pipeline's hazard unit whether each operand read is valid. It sits between decode (reads, reserves) and writeback (writes) in the pipelined CPU datapath.

---
 rtl/regfile_scoreboard_if.sv | 28 ++
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// Pipeline <-> register file bundle: writeback, decode reserve, and read ports.
// master = pipeline (decode/writeback side), slave = regfile_scoreboard.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       RegWrite;
    logic [ADDR_W-1:0]          WriteRegister;
    logic [DATA_W-1:0]          WriteData;
    logic                       Reserve;
    logic [ADDR_W-1:0]          ReserveRegister;
    logic                       ReserveOk;
    logic [NUM_RD*ADDR_W-1:0]   ReadRegister;
    logic [NUM_RD*DATA_W-1:0]   ReadData;
    logic [NUM_RD-1:0]          ReadReady;
    logic [ADDR_W:0]            PendingCount;

    modport master (
        output RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister, ReadRegister,
        input  ReserveOk, ReadData, ReadReady, PendingCount
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister, ReadRegister,
        output ReserveOk, ReadData, ReadReady, PendingCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with hardwired zero register and pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding onto read ports.

// One combinational read port; instantiated once per lane.
module regfile_rd_port #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             pending,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_ready
);
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NUM_REGS - 1);

    logic is_xzr;
    assign is_xzr = (rd_addr == XZR);

`ifdef REGFILE_BYPASS_EN
    logic byp_hit;
    assign byp_hit = wr_en && (wr_addr == rd_addr) && !is_xzr;

    always_comb begin
        rd_data  = is_xzr ? '0 : regs[rd_addr];
        rd_ready = is_xzr || !pending[rd_addr];
        if (byp_hit) begin
            rd_data  = wr_data;
            rd_ready = 1'b1;
        end
    end
`else
    // Without forwarding the writeback inputs are intentionally ignored here.
    logic unused_byp;
    assign unused_byp = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        rd_data  = is_xzr ? '0 : regs[rd_addr];
        rd_ready = is_xzr || !pending[rd_addr];
    end
`endif
endmodule

module regfile_scoreboard #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);
    localparam logic [ADDR_W-1:0] XZR = ADDR_W'(NUM_REGS - 1);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             pending;
    logic [ADDR_W:0]                 pend_cnt;

    logic wr_live, res_ok, res_acc, cnt_inc, cnt_dec;

    assign wr_live = bus.RegWrite && (bus.WriteRegister != XZR);

    // A reserve may land on a pending register only if its writeback retires this edge.
    assign res_ok  = !pending[bus.ReserveRegister] ||
                     (bus.RegWrite && (bus.WriteRegister == bus.ReserveRegister));
    assign res_acc = bus.Reserve && res_ok && (bus.ReserveRegister != XZR);

    assign cnt_inc = res_acc && !pending[bus.ReserveRegister];
    assign cnt_dec = wr_live && pending[bus.WriteRegister] &&
                     !(res_acc && (bus.ReserveRegister == bus.WriteRegister));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs     <= '0;
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_live) begin
                regs[bus.WriteRegister]    <= bus.WriteData;
                pending[bus.WriteRegister] <= 1'b0;
            end
            // Ordered after the write clear so a same-register reserve leaves it pending.
            if (res_acc)
                pending[bus.ReserveRegister] <= 1'b1;
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    assign bus.ReserveOk    = res_ok;
    assign bus.PendingCount = pend_cnt;

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_ready;

    assign rd_addr       = bus.ReadRegister;
    assign bus.ReadData  = rd_data;
    assign bus.ReadReady = rd_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_rd
            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .NUM_REGS (NUM_REGS),
                .ADDR_W   (ADDR_W)
            ) u_rd (
                .regs     (regs),
                .pending  (pending),
                .rd_addr  (rd_addr[i]),
                .wr_en    (bus.RegWrite),
                .wr_addr  (bus.WriteRegister),
                .wr_data  (bus.WriteData),
                .rd_data  (rd_data[i]),
                .rd_ready (rd_ready[i])
            );
        end
    endgenerate
endmodule
